// File: rtl/delayed_branch_queue.sv
// delayed_branch_queue: ordered holding queue and resolver for the delayed
// halves of converted branches. Accepts up to two entries per cycle (p0 older
// than p1), resolves the oldest entry against N/V/Z when stage 3 asks, and
// turns a taken entry into a one-shot redirect plus a one-cycle flush.
// Optional statistics counters (fire_cnt, drop_cnt) are built when the
// macro DBQ_STATS_EN is defined.
module delayed_branch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push0_valid,
    input  logic [15:0]                  push0_word,
    input  logic [2:0]                   push0_cond,
    input  logic                         push1_valid,
    input  logic [15:0]                  push1_word,
    input  logic [2:0]                   push1_cond,
    output logic                         full,
    input  logic                         resolve,
    input  logic                         N,
    input  logic                         V,
    input  logic                         Z,
    output logic                         redirect_valid,
    output logic [15:0]                  redirect_word,
    input  logic                         redirect_ready,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef DBQ_STATS_EN
    output logic [CNT_W-1:0]             fire_cnt,
    output logic [CNT_W-1:0]             drop_cnt,
`endif
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, PEND, FIRE} state_t;

    state_t          state_q;
    logic [15:0]     word_q [DEPTH];
    logic [2:0]      cond_q [DEPTH];
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic            redirect_valid_q;
    logic [15:0]     redirect_word_q;
    logic            flush_q;
    logic            err_q;

    logic            lt;
    logic            condTrue;
    logic            accepting;
    logic            acc0;
    logic            acc1;
    logic            dropAny;
    logic [PW-1:0]   addr0;
    logic [PW-1:0]   addr1;
    logic [PW-1:0]   tail_d;
    logic [CW:0]     cntPush;
    logic [CW-1:0]   count_d;
    logic            resolveIdle;
    logic            taken;
    logic            popped;

    // Head condition evaluation, push acceptance and next occupancy
    always_comb begin
        lt = N ^ V;
        condTrue = 1'b0;
        case (cond_q[head_q])
            3'd0: condTrue = 1'b0;
            3'd1: condTrue = 1'b1;
            3'd2: condTrue = Z;
            3'd3: condTrue = !Z;
            3'd4: condTrue = lt;
            3'd5: condTrue = Z | lt;
            3'd6: condTrue = !Z & !lt;
            3'd7: condTrue = !lt;
            default: condTrue = 1'b0;
        endcase
        accepting   = (state_q != FIRE);
        acc0        = accepting && push0_valid && ({1'b0, count_q} < (CW+1)'(DEPTH));
        acc1        = accepting && push1_valid &&
                      (({1'b0, count_q} + (CW+1)'(acc0)) < (CW+1)'(DEPTH));
        dropAny     = accepting && ((push0_valid && !acc0) || (push1_valid && !acc1));
        addr0       = tail_q;
        addr1       = tail_q + PW'(acc0);
        tail_d      = tail_q + PW'(acc0) + PW'(acc1);
        cntPush     = {1'b0, count_q} + (CW+1)'(acc0) + (CW+1)'(acc1);
        resolveIdle = (state_q == IDLE) && resolve;
        taken       = (state_q == PEND) && resolve && condTrue;
        popped      = (state_q == PEND) && resolve && !condTrue;
        count_d     = popped ? CW'(cntPush - (CW+1)'(1)) : CW'(cntPush);
    end

    // Entry storage; contents are only meaningful between head and tail
    always_ff @(posedge clk) begin
        if (acc0) begin
            word_q[addr0] <= push0_word;
            cond_q[addr0] <= push0_cond;
        end
        if (acc1) begin
            word_q[addr1] <= push1_word;
            cond_q[addr1] <= push1_cond;
        end
    end

    // Control FSM: pointers, occupancy, redirect handshake, flush pulse, sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_word_q  <= '0;
            flush_q          <= 1'b0;
            err_q            <= 1'b0;
        end else begin
            case (state_q)
                IDLE, PEND: begin
                    flush_q <= 1'b0;
                    if (dropAny || resolveIdle) begin
                        err_q <= 1'b1;
                    end
                    if (taken) begin
                        state_q          <= FIRE;
                        redirect_valid_q <= 1'b1;
                        redirect_word_q  <= word_q[head_q];
                        flush_q          <= 1'b1;
                        count_q          <= '0;
                        head_q           <= tail_d;
                        tail_q           <= tail_d;
                    end else begin
                        tail_q  <= tail_d;
                        count_q <= count_d;
                        state_q <= (count_d != '0) ? PEND : IDLE;
                        if (popped) begin
                            head_q <= head_q + PW'(1);
                        end
                    end
                end
                FIRE: begin
                    flush_q <= 1'b0;
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DBQ_STATS_EN
    logic [CNT_W-1:0] fire_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    // Saturating counts of taken and not-taken resolutions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (taken && (fire_cnt_q != '1)) begin
                fire_cnt_q <= fire_cnt_q + CNT_W'(1);
            end
            if (popped && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fire_cnt = fire_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

    assign full           = (count_q > CW'(DEPTH - 2));
    assign count          = count_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_word  = redirect_word_q;
    assign flush          = flush_q;
    assign err            = err_q;

endmodule

// File: tb/tb_delayed_branch_queue.sv
// tb_delayed_branch_queue: self-checking bench for delayed_branch_queue.
// A behavioural queue model predicts occupancy, error and flush; expected
// redirect words are queued when a taken resolve is driven and popped when
// the DUT raises redirect_valid. Define DBQ_STATS_EN to also check counters.
module tb_delayed_branch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           push0_valid = 1'b0;
    logic [15:0]    push0_word  = '0;
    logic [2:0]     push0_cond  = '0;
    logic           push1_valid = 1'b0;
    logic [15:0]    push1_word  = '0;
    logic [2:0]     push1_cond  = '0;
    logic           full;
    logic           resolve = 1'b0;
    logic           N = 1'b0;
    logic           V = 1'b0;
    logic           Z = 1'b0;
    logic           redirect_valid;
    logic [15:0]    redirect_word;
    logic           redirect_ready = 1'b0;
    logic           flush;
    logic [CW-1:0]  count;
    logic           err;
`ifdef DBQ_STATS_EN
    logic [15:0]    fire_cnt;
    logic [15:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    delayed_branch_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .push0_valid(push0_valid), .push0_word(push0_word), .push0_cond(push0_cond),
        .push1_valid(push1_valid), .push1_word(push1_word), .push1_cond(push1_cond),
        .full(full), .resolve(resolve), .N(N), .V(V), .Z(Z),
        .redirect_valid(redirect_valid), .redirect_word(redirect_word),
        .redirect_ready(redirect_ready), .flush(flush), .count(count),
`ifdef DBQ_STATS_EN
        .fire_cnt(fire_cnt), .drop_cnt(drop_cnt),
`endif
        .err(err)
    );

    typedef struct {
        logic [15:0] w;
        logic [2:0]  c;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        mq[$];
    logic [15:0] expRedir[$];
    logic [15:0] mCur = '0;
    bit          mFire = 0;
    bit          mErr = 0;
    bit          mFlush = 0;
    bit          lastRv = 0;
    int          mFireCnt = 0;
    int          mDropCnt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic bit condEval(input logic [2:0] c, input bit n, input bit v, input bit z);
        bit l;
        l = n ^ v;
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return l;
            3'd5: return z | l;
            3'd6: return !z && !l;
            default: return !l;
        endcase
    endfunction

    task automatic modelClear();
        mq.delete();
        expRedir.delete();
        mFire = 0; mErr = 0; mFlush = 0; lastRv = 0;
        mFireCnt = 0; mDropCnt = 0;
    endtask

    task automatic checkAll();
        checkOutput("count", 32'(count), 32'(mq.size()));
        checkOutput("full", 32'(full), 32'(mq.size() > DEPTH - 2));
        checkOutput("err", 32'(err), 32'(mErr));
        checkOutput("redirect_valid", 32'(redirect_valid), 32'(mFire));
        checkOutput("flush", 32'(flush), 32'(mFlush));
        if (redirect_valid && !lastRv) begin
            if (expRedir.size() == 0) begin
                checkOutput("redirect_unexpected", 32'(1), 32'(0));
            end else begin
                mCur = expRedir.pop_front();
                checkOutput("redirect_word", 32'(redirect_word), 32'(mCur));
            end
        end else if (redirect_valid) begin
            checkOutput("redirect_hold", 32'(redirect_word), 32'(mCur));
        end
        lastRv = redirect_valid;
`ifdef DBQ_STATS_EN
        checkOutput("fire_cnt", 32'(fire_cnt), 32'(mFireCnt));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDropCnt));
`endif
    endtask

    // One clock of stimulus: model predicts the edge, then outputs are checked #1 after it
    task automatic applyStimulus(input bit p0v, input logic [15:0] p0w, input logic [2:0] p0c,
                                 input bit p1v, input logic [15:0] p1w, input logic [2:0] p1c,
                                 input bit res, input bit n, input bit v, input bit z,
                                 input bit rdy);
        int pre;
        push0_valid = p0v; push0_word = p0w; push0_cond = p0c;
        push1_valid = p1v; push1_word = p1w; push1_cond = p1c;
        resolve = res; N = n; V = v; Z = z; redirect_ready = rdy;
        mFlush = 0;
        if (mFire) begin
            if (rdy) mFire = 0;
        end else begin
            pre = mq.size();
            if (p0v) begin
                if (mq.size() < DEPTH) mq.push_back('{p0w, p0c});
                else mErr = 1;
            end
            if (p1v) begin
                if (mq.size() < DEPTH) mq.push_back('{p1w, p1c});
                else mErr = 1;
            end
            if (res) begin
                if (pre == 0) begin
                    mErr = 1;
                end else if (condEval(mq[0].c, n, v, z)) begin
                    expRedir.push_back(mq[0].w);
                    mq.delete();
                    mFire = 1;
                    mFlush = 1;
                    if (mFireCnt < 65535) mFireCnt++;
                end else begin
                    void'(mq.pop_front());
                    if (mDropCnt < 65535) mDropCnt++;
                end
            end
        end
        @(posedge clk);
        #1;
        push0_valid = 0; push1_valid = 0; resolve = 0; redirect_ready = 0;
        checkAll();
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 0, 0, 0, 0, rdy);
    endtask

    task automatic doReset();
        rst = 0;
        push0_valid = 0; push1_valid = 0; resolve = 0; redirect_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        modelClear();
        checkOutput("rst_count", 32'(count), 32'(0));
        checkOutput("rst_full", 32'(full), 32'(0));
        checkOutput("rst_rv", 32'(redirect_valid), 32'(0));
        checkOutput("rst_rword", 32'(redirect_word), 32'(0));
        checkOutput("rst_flush", 32'(flush), 32'(0));
        checkOutput("rst_err", 32'(err), 32'(0));
        rst = 1;
    endtask

    initial begin
        $display("[TB] start");
        doReset();

        // Two-lane push, then two not-taken resolves drain the queue
        applyStimulus(1, 16'h2000, 3'd2, 1, 16'h2012, 3'd3, 0, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 1, 0);
        idle(0);

        // Taken LT resolve, redirect held three cycles, then accepted
        applyStimulus(1, 16'h2040, 3'd4, 1, 16'h2050, 3'd1, 0, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 1, 0, 0, 0);
        repeat (3) idle(0);
        idle(1);
        idle(0);

        // Fill to DEPTH, overflow push, pops with same-cycle pushes
        applyStimulus(1, 16'h3000, 3'd0, 1, 16'h3001, 3'd0, 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h3002, 3'd0, 1, 16'h3003, 3'd0, 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h3004, 3'd0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 0);
        idle(0);
        applyStimulus(0, 16'h0, 3'd0, 1, 16'h3005, 3'd0, 1, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 0, 0);
        applyStimulus(1, 16'h3006, 3'd6, 0, 16'h0, 3'd0, 1, 0, 0, 1, 0);
        repeat (4) applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 1, 0);
        idle(0);

        // Resolve on an empty queue sets err
        doReset();
        applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 0, 0);
        idle(0);

        // Halt head fires like AL; reset during FIRE clears everything at once
        doReset();
        applyStimulus(1, 16'h27F3, 3'd1, 0, 16'h0, 3'd0, 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h4444, 3'd1, 1, 16'h4445, 3'd1, 1, 0, 0, 0, 0);
        #2;
        rst = 0;
        #1;
        checkOutput("midfire_rv", 32'(redirect_valid), 32'(0));
        checkOutput("midfire_count", 32'(count), 32'(0));
        checkOutput("midfire_flush", 32'(flush), 32'(0));
        @(posedge clk);
        #1;
        modelClear();
        rst = 1;
        idle(0);

`ifdef DBQ_STATS_EN
        // Three not-taken and two taken resolutions
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 16'h5000, 3'd0, 0, 16'h0, 3'd0, 0, 0, 0, 0, 0);
            applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 16'h5100, 3'd1, 0, 16'h0, 3'd0, 0, 0, 0, 0, 0);
            applyStimulus(0, 16'h0, 3'd0, 0, 16'h0, 3'd0, 1, 0, 0, 0, 0);
            idle(1);
        end
        checkOutput("stats_drop", 32'(drop_cnt), 32'(3));
        checkOutput("stats_fire", 32'(fire_cnt), 32'(2));
`endif

        // Random traffic against the model
        doReset();
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 2) == 0));
        end
        repeat (2) idle(1);
        checkOutput("scoreboard_empty", 32'(expRedir.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
